top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 CLOCK_50  input  1  sole clock; all logic on the rising edge.
REQ-002 KEY  input  4  push keys, active-low at the pin. KEY[3] is the reset key. Internal reset rst = ~KEY[3], registered through 2 flops; rst is synchronous and active-high. KEY[2:0] are unused.
REQ-003 done  output  1  high once the output image is complete.
REQ-004 readMem: internal 8-bit x 65536 byte array, hierarchically visible; holds the input BMP file starting at byte 0. Loaded by the bench; never written by the DUT.
REQ-005 writeMem: internal 8-bit x 65536 byte array, hierarchically visible; receives the output BMP starting at byte 0.
REQ-006 Both memories use a 16-bit byte address, synchronous read with 1-cycle latency, and one write port of 1 byte per cycle.

Function
REQ-007 Purpose: crop a 24-bit uncompressed bottom-up BMP to the bounding box of its foreground pixels.
REQ-008 Header fields are little-endian: pixel data offset at bytes 10-13, width W at 18-21, height H at 22-25, bpp at 28-29. Only the low 16 bits of W and H are used.
REQ-009 Input row stride is S = (3W+3) & ~3. Pixel (x,y) starts at offset + y*S + 3x, in B,G,R byte order. y=0 is the first stored row.
REQ-010 A pixel is foreground if any of its B, G or R bytes is < 0x80.
REQ-011 The FSM states are IDLE, PARSE, SCAN, HDR, COPY, DONE. rst forces IDLE. The FSM leaves IDLE on the first cycle rst is low.
REQ-012 PARSE: read the header fields. If bpp != 24, go straight to DONE with writeMem untouched.
REQ-013 SCAN: visit every pixel once and track xmin, xmax, ymin, ymax of foreground pixels.
REQ-014 If no pixel is foreground, the bounding box is the whole image (0..W-1, 0..H-1).
REQ-015 Output dimensions: w = xmax-xmin+1, h = ymax-ymin+1, output stride R = (3w+3) & ~3.
REQ-016 HDR: write bytes 0-53 by copying readMem[0..53], except for these overwritten fields:
 - bytes 2-5 = 54 + R*h
 - bytes 10-13 = 54
 - bytes 18-21 = w
 - bytes 22-25 = h
 - bytes 34-37 = R*h
REQ-017 COPY: for each output row j = 0..h-1 in order, write the 3w bytes of input row ymin+j, columns xmin..xmax, then zero padding up to R bytes. Row j starts at address 54 + j*R.
REQ-018 writeMem bytes beyond 54 + R*h are not modified.
REQ-019 Arithmetic uses at least 32 bits internally. Address arithmetic wraps modulo 65536. Input files larger than 64 KiB are unsupported.
REQ-020 DONE: done = 1, held until rst. No further writes occur.

Reset
REQ-021 While rst = 1: done = 0, FSM is in IDLE, all counters and bounding-box registers are cleared, and no writes to writeMem occur.
REQ-022 rst asserted in any state aborts the run on the next edge. After release, processing restarts from PARSE using the current readMem contents.
REQ-023 Memory contents are not cleared by reset.
REQ-024 done first rises no earlier than 1 cycle after the last writeMem write.

Verification
REQ-025 8x8 all-white 24-bit BMP, black block at rows 2-4, cols 3-6; pulse KEY[3] low -> done = 1, header w = 4, h = 3, bytes 2-5 = 90, bytes 34-37 = 36, every pixel byte = 0x00.
REQ-026 5x5 white image with a single pixel (1,2) = B,G,R 10,20,30 -> w = h = 1, R = 4, file size 58, bytes 54-57 = 0A 14 1E 00.
REQ-027 4x2 all-white image -> output equals the input (w = 4, h = 2, R = 12, file size 78).
REQ-028 Header with bpp = 8 -> done = 1 within 100 cycles of reset release, writeMem unchanged.
REQ-029 Assert KEY[3] low midway through COPY -> done = 0 on the next edge. After release, the output is re-produced correctly and done = 1.
REQ-030 Full-frame 3x3 image with a dark top-right corner pixel only (x=2, y=2) -> w = h = 1, output pixel equals the input corner pixel, padding byte = 00.

Source files
------------

// File: rtl/top.sv
// Crops a 24-bit bottom-up BMP held in readMem to the bounding box of its dark pixels
// and writes the resulting BMP (rewritten header + padded rows) into writeMem.
module top (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, PARSE, SCAN, HDR, COPY, DONE} state_t;

  logic [7:0] readMem  [0:65535];
  logic [7:0] writeMem [0:65535];

  function automatic logic [31:0] stride(input logic [31:0] w);
    return (w + (w << 1) + 32'd3) & ~32'd3;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] v, input logic [1:0] i);
    return v[{i, 3'b000} +: 8];
  endfunction

  logic        rst_meta_q, rst_q;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, bp_q, bp_d, cx_q, cx_d, cy_q, cy_d;
  logic [1:0]  cc_q, cc_d;
  logic [31:0] k_q, k_d, j_q, j_d, dst_q, dst_d, src_q, src_d;
  logic [31:0] rowbase_q, rowbase_d, ybase_q, ybase_d, off_q, off_d;
  logic [15:0] w_in_q, w_in_d, h_in_q, h_in_d, bpp_q, bpp_d;
  logic [15:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic        found_q, found_d, fgacc_q, fgacc_d, drain_q, drain_d, done_q;
  logic [15:0] ra_d;
  logic [7:0]  rd_q;
  logic        wv_p1, wv_d, ovsel_p1, ovsel_d, pv_p1, pv_d, sv_p1, sv_d;
  logic [15:0] wa_p1, wa_d, sx_p1, sx_d, sy_p1, sy_d;
  logic [7:0]  ov_p1, ov_d;
  logic [4:0]  pidx_p1, pidx_d;
  logic [1:0]  scc_p1, scc_d, bsel;
  logic [31:0] sbase_p1, sbase_d;
  logic        fg;
  logic [31:0] s_in, ow, oh, ow3, rstr, img_sz;
  logic        unused_key_bits;

  assign unused_key_bits = ^KEY[2:0];
  assign done   = done_q;
  assign s_in   = stride({16'd0, w_in_q});
  assign ow     = {16'd0, xmax_q} - {16'd0, xmin_q} + 32'd1;
  assign oh     = {16'd0, ymax_q} - {16'd0, ymin_q} + 32'd1;
  assign ow3    = ow + (ow << 1);
  assign rstr   = stride(ow);
  assign img_sz = rstr * oh;
  // Every overwritten header field starts at an address whose low bits are 2'b10.
  assign bsel   = cnt_q[1:0] - 2'd2;

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  bp_d = bp_q;  cc_d = cc_q;  cx_d = cx_q;  cy_d = cy_q;
    k_d = k_q;  j_d = j_q;  dst_d = dst_q;  src_d = src_q;  rowbase_d = rowbase_q;
    ybase_d = ybase_q;  off_d = off_q;  w_in_d = w_in_q;  h_in_d = h_in_q;  bpp_d = bpp_q;
    xmin_d = xmin_q;  xmax_d = xmax_q;  ymin_d = ymin_q;  ymax_d = ymax_q;
    found_d = found_q;  fgacc_d = fgacc_q;  drain_d = drain_q;
    ra_d = 16'd0;  wv_d = 1'b0;  wa_d = wa_p1;  ov_d = 8'h00;  ovsel_d = 1'b0;
    pv_d = 1'b0;  pidx_d = pidx_p1;  sv_d = 1'b0;  scc_d = scc_p1;
    sx_d = sx_p1;  sy_d = sy_p1;  sbase_d = sbase_p1;
    fg = fgacc_q | ~rd_q[7];

    // stage p1: header bytes returned from readMem
    if (pv_p1) begin
      case (pidx_p1)
        5'd10: off_d[7:0]   = rd_q;
        5'd11: off_d[15:8]  = rd_q;
        5'd12: off_d[23:16] = rd_q;
        5'd13: off_d[31:24] = rd_q;
        5'd18: w_in_d[7:0]  = rd_q;
        5'd19: w_in_d[15:8] = rd_q;
        5'd22: h_in_d[7:0]  = rd_q;
        5'd23: h_in_d[15:8] = rd_q;
        5'd28: bpp_d[7:0]   = rd_q;
        5'd29: bpp_d[15:8]  = rd_q;
        default: ;
      endcase
    end

    // stage p1: pixel bytes returned from readMem
    if (sv_p1) begin
      if (scc_p1 == 2'd2) begin
        fgacc_d = 1'b0;
        if (fg) begin
          if (!found_q) begin
            found_d = 1'b1;  ybase_d = sbase_p1;
            xmin_d = sx_p1;  xmax_d = sx_p1;  ymin_d = sy_p1;  ymax_d = sy_p1;
          end else begin
            if (sx_p1 < xmin_q) xmin_d = sx_p1;
            if (sx_p1 > xmax_q) xmax_d = sx_p1;
            if (sy_p1 < ymin_q) ymin_d = sy_p1;
            if (sy_p1 > ymax_q) ymax_d = sy_p1;
          end
        end
      end else begin
        fgacc_d = fg;
      end
    end

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;  state_d = PARSE;
      end
      PARSE: begin
        if (cnt_q < 16'd30) begin
          ra_d = cnt_q;  pv_d = 1'b1;  pidx_d = cnt_q[4:0];
        end
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'd31) begin
          if (bpp_q != 16'd24) state_d = DONE;
          else begin
            state_d = SCAN;  bp_d = 16'd0;  cc_d = 2'd0;  cx_d = 16'd0;  cy_d = 16'd0;
            rowbase_d = off_q;  found_d = 1'b0;  fgacc_d = 1'b0;  drain_d = 1'b0;
          end
        end
      end
      SCAN: begin
        if (drain_q) begin
          drain_d = 1'b0;  cnt_d = 16'd0;  state_d = HDR;
          if (!found_d) begin
            xmin_d = 16'd0;  xmax_d = w_in_q - 16'd1;
            ymin_d = 16'd0;  ymax_d = h_in_q - 16'd1;  ybase_d = off_q;
          end
        end else begin
          ra_d = rowbase_q[15:0] + bp_q;  sv_d = 1'b1;
          scc_d = cc_q;  sx_d = cx_q;  sy_d = cy_q;  sbase_d = rowbase_q;
          bp_d = bp_q + 16'd1;
          if (cc_q != 2'd2) cc_d = cc_q + 2'd1;
          else begin
            cc_d = 2'd0;  cx_d = cx_q + 16'd1;
            if (cx_q == w_in_q - 16'd1) begin
              cx_d = 16'd0;  bp_d = 16'd0;  cy_d = cy_q + 16'd1;  rowbase_d = rowbase_q + s_in;
              if (cy_q == h_in_q - 16'd1) drain_d = 1'b1;
            end
          end
        end
      end
      HDR: begin
        ra_d = cnt_q;  wv_d = 1'b1;  wa_d = cnt_q;
        if (cnt_q >= 16'd2 && cnt_q <= 16'd5) begin
          ovsel_d = 1'b1;  ov_d = byte_of(img_sz + 32'd54, bsel);
        end else if (cnt_q >= 16'd10 && cnt_q <= 16'd13) begin
          ovsel_d = 1'b1;  ov_d = byte_of(32'd54, bsel);
        end else if (cnt_q >= 16'd18 && cnt_q <= 16'd21) begin
          ovsel_d = 1'b1;  ov_d = byte_of(ow, bsel);
        end else if (cnt_q >= 16'd22 && cnt_q <= 16'd25) begin
          ovsel_d = 1'b1;  ov_d = byte_of(oh, bsel);
        end else if (cnt_q >= 16'd34 && cnt_q <= 16'd37) begin
          ovsel_d = 1'b1;  ov_d = byte_of(img_sz, bsel);
        end
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'd53) begin
          state_d = COPY;  k_d = 32'd0;  j_d = 32'd0;  dst_d = 32'd54;  drain_d = 1'b0;
          src_d = ybase_q + {16'd0, xmin_q} + {15'd0, xmin_q, 1'b0};
        end
      end
      COPY: begin
        if (drain_q) begin
          drain_d = 1'b0;  state_d = DONE;
        end else begin
          wv_d = 1'b1;  wa_d = dst_q[15:0];  dst_d = dst_q + 32'd1;
          if (k_q < ow3) ra_d = src_q[15:0] + k_q[15:0];
          else ovsel_d = 1'b1;
          if (k_q == rstr - 32'd1) begin
            k_d = 32'd0;  j_d = j_q + 32'd1;  src_d = src_q + s_in;
            if (j_q == oh - 32'd1) drain_d = 1'b1;
          end else begin
            k_d = k_q + 32'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    rst_meta_q <= ~KEY[3];
    rst_q      <= rst_meta_q;
    if (rst_q) begin
      state_q <= IDLE;  cnt_q <= '0;  bp_q <= '0;  cc_q <= '0;  cx_q <= '0;  cy_q <= '0;
      k_q <= '0;  j_q <= '0;  dst_q <= '0;  found_q <= 1'b0;  fgacc_q <= 1'b0;
      xmin_q <= '0;  xmax_q <= '0;  ymin_q <= '0;  ymax_q <= '0;  drain_q <= 1'b0;
      wv_p1 <= 1'b0;  pv_p1 <= 1'b0;  sv_p1 <= 1'b0;  done_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  bp_q <= bp_d;  cc_q <= cc_d;  cx_q <= cx_d;
      cy_q <= cy_d;  k_q <= k_d;  j_q <= j_d;  dst_q <= dst_d;  found_q <= found_d;
      fgacc_q <= fgacc_d;  xmin_q <= xmin_d;  xmax_q <= xmax_d;  ymin_q <= ymin_d;
      ymax_q <= ymax_d;  drain_q <= drain_d;
      wv_p1 <= wv_d;  pv_p1 <= pv_d;  sv_p1 <= sv_d;  done_q <= (state_q == DONE);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    rd_q <= readMem[ra_d];
    off_q <= off_d;  w_in_q <= w_in_d;  h_in_q <= h_in_d;  bpp_q <= bpp_d;
    rowbase_q <= rowbase_d;  ybase_q <= ybase_d;  src_q <= src_d;
    wa_p1 <= wa_d;  ov_p1 <= ov_d;  ovsel_p1 <= ovsel_d;  pidx_p1 <= pidx_d;
    scc_p1 <= scc_d;  sx_p1 <= sx_d;  sy_p1 <= sy_d;  sbase_p1 <= sbase_d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (wv_p1 && !rst_q) writeMem[wa_p1] <= ovsel_p1 ? ov_p1 : rd_q;
  end
endmodule

// File: tb/tb_top.sv
// Bench for the BMP bounding-box cropper: builds BMP images, predicts the cropped output
// with a behavioural model and compares writeMem plus hand-computed literals.
module tb_top;
  logic       clk = 1'b0;
  logic [3:0] key = 4'b0111;
  logic       done;
  logic       hold = 1'b0;
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] img     [0:1023];
  logic [7:0] exp_mem [0:1023];
  int         exp_len;

  top dut (.CLOCK_50(clk), .KEY(key), .done(done));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // done must read low on every cycle while reset is being held
  always @(negedge clk) if (hold) check("done_in_reset", int'(done), 0);

  task automatic put32(input int a, input int v);
    for (int b = 0; b < 4; b++) img[a + b] = 8'((v >> (8 * b)) & 255);
  endtask

  task automatic build_bmp(input int w, input int h, input int bpp);
    int s;
    s = (3 * w + 3) & ~3;
    for (int i = 0; i < 1024; i++) img[i] = 8'h00;
    img[0] = 8'h42;  img[1] = 8'h4D;
    put32(2, 54 + s * h);  put32(10, 54);  put32(14, 40);
    put32(18, w);  put32(22, h);  img[26] = 8'd1;  img[28] = 8'(bpp);
    put32(34, s * h);  img[38] = 8'h13;  img[42] = 8'h13;
    for (int y = 0; y < h; y++)
      for (int k = 0; k < s; k++) img[54 + y * s + k] = (k < 3 * w) ? 8'hFF : 8'hEE;
  endtask

  task automatic set_px(input int x, input int y, input int b, input int g, input int r);
    int s, a;
    s = (3 * (int'(img[18]) | (int'(img[19]) << 8)) + 3) & ~3;
    a = 54 + y * s + 3 * x;
    img[a] = 8'(b);  img[a + 1] = 8'(g);  img[a + 2] = 8'(r);
  endtask

  function automatic int rd32(input int a);
    return int'(img[a]) | (int'(img[a + 1]) << 8) | (int'(img[a + 2]) << 16) | (int'(img[a + 3]) << 24);
  endfunction

  task automatic model();
    int ww, hh, off, bpp, s, xmin, xmax, ymin, ymax, w, h, r, a;
    bit any;
    off = rd32(10);  ww = rd32(18) & 16'hFFFF;  hh = rd32(22) & 16'hFFFF;
    bpp = int'(img[28]) | (int'(img[29]) << 8);
    exp_len = 0;
    if (bpp != 24) return;
    s = (3 * ww + 3) & ~3;
    any = 0;  xmin = ww;  xmax = -1;  ymin = hh;  ymax = -1;
    for (int y = 0; y < hh; y++)
      for (int x = 0; x < ww; x++) begin
        a = off + y * s + 3 * x;
        if (img[a] < 8'h80 || img[a + 1] < 8'h80 || img[a + 2] < 8'h80) begin
          any = 1;
          if (x < xmin) xmin = x;
          if (x > xmax) xmax = x;
          if (y < ymin) ymin = y;
          if (y > ymax) ymax = y;
        end
      end
    if (!any) begin xmin = 0;  xmax = ww - 1;  ymin = 0;  ymax = hh - 1; end
    w = xmax - xmin + 1;  h = ymax - ymin + 1;  r = (3 * w + 3) & ~3;
    for (int i = 0; i < 54; i++) exp_mem[i] = img[i];
    for (int b = 0; b < 4; b++) begin
      exp_mem[2 + b]  = 8'(((54 + r * h) >> (8 * b)) & 255);
      exp_mem[10 + b] = 8'((54 >> (8 * b)) & 255);
      exp_mem[18 + b] = 8'((w >> (8 * b)) & 255);
      exp_mem[22 + b] = 8'((h >> (8 * b)) & 255);
      exp_mem[34 + b] = 8'(((r * h) >> (8 * b)) & 255);
    end
    for (int j = 0; j < h; j++)
      for (int k = 0; k < r; k++)
        exp_mem[54 + j * r + k] = (k < 3 * w) ? img[off + (ymin + j) * s + 3 * xmin + k] : 8'h00;
    exp_len = 54 + r * h;
  endtask

  // Hold reset, reload readMem from img and prefill writeMem with 0xA5, then release.
  task automatic start_run();
    @(negedge clk);  key[3] = 1'b0;
    repeat (3) @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      dut.readMem[i]  = img[i];
      dut.writeMem[i] = 8'hA5;
    end
    repeat (3) @(negedge clk);
    hold = 1'b0;  key[3] = 1'b1;
  endtask

  task automatic wait_done(input string name, input int limit, output int cycles);
    cycles = 0;
    while (!done && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    check({name, "_done"}, int'(done), 1);
  endtask

  task automatic check_out(input string tag);
    int e;
    for (int i = 0; i < exp_len + 4; i++) begin
      e = (i < exp_len) ? int'(exp_mem[i]) : 8'hA5;
      check($sformatf("%s_byte%0d", tag, i), int'(dut.writeMem[i]), e);
    end
  endtask

  initial begin
    int cyc;
    // 8x8 white with a black block at rows 2-4, cols 3-6
    build_bmp(8, 8, 24);
    for (int y = 2; y <= 4; y++) for (int x = 3; x <= 6; x++) set_px(x, y, 0, 0, 0);
    model();
    check("blk_model_len", exp_len, 90);
    start_run();
    check("blk_done_after_release", int'(done), 0);
    wait_done("blk", 5000, cyc);
    check_out("blk");
    check("blk_w", int'(dut.writeMem[18]), 4);
    check("blk_h", int'(dut.writeMem[22]), 3);
    check("blk_size", int'(dut.writeMem[2]), 90);
    check("blk_imgsz", int'(dut.writeMem[34]), 36);
    check("blk_off", int'(dut.writeMem[10]), 54);
    for (int i = 54; i < 90; i++) check($sformatf("blk_px%0d", i), int'(dut.writeMem[i]), 0);
    repeat (5) @(negedge clk);
    check("blk_done_held", int'(done), 1);

    // 5x5 white with a single pixel (1,2)
    build_bmp(5, 5, 24);
    set_px(1, 2, 10, 20, 30);
    model();
    start_run();
    wait_done("one", 5000, cyc);
    check_out("one");
    check("one_size", int'(dut.writeMem[2]), 58);
    check("one_b54", int'(dut.writeMem[54]), 8'h0A);
    check("one_b55", int'(dut.writeMem[55]), 8'h14);
    check("one_b56", int'(dut.writeMem[56]), 8'h1E);
    check("one_b57", int'(dut.writeMem[57]), 8'h00);

    // 4x2 all-white: output equals the input
    build_bmp(4, 2, 24);
    model();
    start_run();
    wait_done("wht", 5000, cyc);
    check_out("wht");
    check("wht_size", int'(dut.writeMem[2]), 78);
    for (int i = 0; i < 78; i++) check($sformatf("wht_eq%0d", i), int'(dut.writeMem[i]), int'(img[i]));

    // 8 bpp header: done quickly, writeMem untouched
    build_bmp(4, 4, 8);
    model();
    start_run();
    wait_done("bpp8", 100, cyc);
    check("bpp8_fast", int'(cyc <= 100), 1);
    check_out("bpp8");
    check("bpp8_b2", int'(dut.writeMem[2]), 8'hA5);
    check("bpp8_b54", int'(dut.writeMem[54]), 8'hA5);

    // 3x3 with only the top-right corner dark
    build_bmp(3, 3, 24);
    set_px(2, 2, 8'h40, 8'h90, 8'hC0);
    model();
    start_run();
    wait_done("cor", 5000, cyc);
    check_out("cor");
    check("cor_w", int'(dut.writeMem[18]), 1);
    check("cor_b54", int'(dut.writeMem[54]), 8'h40);
    check("cor_b55", int'(dut.writeMem[55]), 8'h90);
    check("cor_b56", int'(dut.writeMem[56]), 8'hC0);
    check("cor_pad", int'(dut.writeMem[57]), 8'h00);

    // abort mid-COPY, then rerun to completion
    build_bmp(8, 8, 24);
    for (int y = 2; y <= 4; y++) for (int x = 3; x <= 6; x++) set_px(x, y, 0, 0, 0);
    model();
    start_run();
    cyc = 0;
    while (dut.writeMem[60] == 8'hA5 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("abt_copy_reached", int'(dut.writeMem[60] != 8'hA5), 1);
    check("abt_not_done", int'(done), 0);
    start_run();
    wait_done("abt", 5000, cyc);
    check_out("abt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
